// File: rtl/clock_sequencer_pkg.sv
// clock_sequencer_pkg: shared widths, default tap masks and parameter legality
// checks for the clock-enable sequencer.
`default_nettype none

package clock_sequencer_pkg;

  localparam logic [11:0] TAP_6M = 12'hAAA;
  localparam logic [11:0] TAP_4M = 12'h249;

  localparam logic [0:0] c_ST_RUN  = 1'b0;
  localparam logic [0:0] c_ST_HELD = 1'b1;

  function automatic int pw(input int phases);
    return $clog2(phases);
  endfunction

  function automatic bit cfg_ok(input int phases, input int q_ph, input int e_ph,
                                input int qn_ph, input int en_ph, input int hold_ph,
                                input int reset_ph, input int max_stretch);
    bit ok;
    ok = (phases >= 4) && (max_stretch >= 1);
    ok = ok && (hold_ph != q_ph) && (hold_ph != e_ph) &&
         (hold_ph != qn_ph) && (hold_ph != en_ph);
    ok = ok && (q_ph >= 0) && (q_ph < phases) && (e_ph >= 0) && (e_ph < phases);
    ok = ok && (qn_ph >= 0) && (qn_ph < phases) && (en_ph >= 0) && (en_ph < phases);
    ok = ok && (hold_ph >= 0) && (hold_ph < phases);
    ok = ok && (reset_ph >= 0) && (reset_ph < phases);
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_sequencer_phase_counter.sv
// phase_counter: modulo-PHASES counter with an advance enable and async reset.
`default_nettype none

module phase_counter
  import clock_sequencer_pkg::*;
#(
  parameter int PHASES      = 12,
  parameter int RESET_PHASE = 3
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  output logic [pw(PHASES)-1:0] phase
);

  localparam int c_pw = pw(PHASES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= c_pw'(RESET_PHASE);
    end else if (advance) begin
      phase <= (phase == c_pw'(PHASES - 1)) ? '0 : phase + c_pw'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_sequencer.sv
// clock_sequencer: free-running tap enables plus a stallable 6809 Q/E phase
// generator whose E-high interval can be stretched in whole CPU cycles.
`default_nettype none

module clock_sequencer
  import clock_sequencer_pkg::*;
#(
  parameter int                        PHASES      = 12,
  parameter int                        N_TAP       = 2,
  parameter logic [N_TAP*PHASES-1:0]   TAP_MASK    = {TAP_4M, TAP_6M},
  parameter int                        Q_PHASE     = 0,
  parameter int                        E_PHASE     = 3,
  parameter int                        QN_PHASE    = 6,
  parameter int                        EN_PHASE    = 9,
  parameter int                        HOLD_PHASE  = 8,
  parameter int                        RESET_PHASE = 3,
  parameter int                        MAX_STRETCH = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stretch_req,
  output logic [N_TAP-1:0]      en_tap,
  output logic                  en_q,
  output logic                  en_e,
  output logic                  en_q_n,
  output logic                  en_e_n,
  output logic                  q_level,
  output logic                  e_level,
  output logic                  stretched,
  output logic                  stretch_timeout,
  output logic [pw(PHASES)-1:0] free_phase,
  output logic [pw(PHASES)-1:0] cpu_phase
);

  localparam int c_pw   = pw(PHASES);
  localparam int c_span = 1 << c_pw;
  localparam int c_lw   = $clog2(MAX_STRETCH + 1);

  localparam logic [c_pw-1:0] c_q_ph    = c_pw'(Q_PHASE);
  localparam logic [c_pw-1:0] c_e_ph    = c_pw'(E_PHASE);
  localparam logic [c_pw-1:0] c_qn_ph   = c_pw'(QN_PHASE);
  localparam logic [c_pw-1:0] c_en_ph   = c_pw'(EN_PHASE);
  localparam logic [c_pw-1:0] c_hold_ph = c_pw'(HOLD_PHASE);
  localparam logic [c_lw-1:0] c_last_lap = c_lw'(MAX_STRETCH - 1);

  if (!cfg_ok(PHASES, Q_PHASE, E_PHASE, QN_PHASE, EN_PHASE, HOLD_PHASE,
              RESET_PHASE, MAX_STRETCH)) begin : g_bad_cfg
    $error("clock_sequencer: illegal parameter combination");
  end

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [c_lw-1:0]  r_laps;
  logic [c_lw-1:0]  w_laps_nxt;
  logic             w_cpu_adv;
  logic             w_timeout;
  logic             w_entry;
  logic             w_lap_pt;
  logic             w_release;
  logic [N_TAP-1:0] w_tap;

  logic [N_TAP-1:0] r_tap;
  logic             r_en_q, r_en_e, r_en_q_n, r_en_e_n;
  logic             r_q_level, r_e_level, r_timeout;

  phase_counter #(.PHASES(PHASES), .RESET_PHASE(RESET_PHASE)) u_free_cnt (
    .clk     (clk),
    .rst     (rst),
    .advance (1'b1),
    .phase   (free_phase)
  );

  phase_counter #(.PHASES(PHASES), .RESET_PHASE(RESET_PHASE)) u_cpu_cnt (
    .clk     (clk),
    .rst     (rst),
    .advance (w_cpu_adv),
    .phase   (cpu_phase)
  );

  // A lap point is where the free counter laps back to the held phase, so a
  // release always realigns the two counters.
  assign w_entry   = (r_state == c_ST_RUN) && (cpu_phase == c_hold_ph) && stretch_req;
  assign w_lap_pt  = (r_state == c_ST_HELD) && (free_phase == c_hold_ph);
  assign w_release = w_lap_pt && (!stretch_req || (r_laps == c_last_lap));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN:  if (w_entry)   w_state_nxt = c_ST_HELD;
      c_ST_HELD: if (w_release) w_state_nxt = c_ST_RUN;
      default:                  w_state_nxt = c_ST_RUN;
    endcase
  end

  always_comb begin
    w_cpu_adv  = 1'b1;
    w_timeout  = 1'b0;
    w_laps_nxt = r_laps;
    case (r_state)
      c_ST_RUN: begin
        if (w_entry) begin
          w_cpu_adv  = 1'b0;
          w_laps_nxt = '0;
        end
      end
      c_ST_HELD: begin
        w_cpu_adv = w_release;
        w_timeout = w_release && stretch_req;
        if (w_lap_pt && !w_release) w_laps_nxt = r_laps + c_lw'(1);
      end
      default: w_cpu_adv = 1'b1;
    endcase
  end

  for (genvar i = 0; i < N_TAP; i++) begin : g_tap
    localparam logic [c_span-1:0] c_mask = c_span'(TAP_MASK[i*PHASES +: PHASES]);
    assign w_tap[i] = c_mask[free_phase];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_laps    <= '0;
      r_tap     <= '0;
      r_en_q    <= 1'b0;
      r_en_e    <= 1'b0;
      r_en_q_n  <= 1'b0;
      r_en_e_n  <= 1'b0;
      r_q_level <= 1'b0;
      r_e_level <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_laps    <= w_laps_nxt;
      r_tap     <= w_tap;
      r_en_q    <= (cpu_phase == c_q_ph);
      r_en_e    <= (cpu_phase == c_e_ph);
      r_en_q_n  <= (cpu_phase == c_qn_ph);
      r_en_e_n  <= (cpu_phase == c_en_ph);
      r_q_level <= r_en_q ? 1'b1 : (r_en_q_n ? 1'b0 : r_q_level);
      r_e_level <= r_en_e ? 1'b1 : (r_en_e_n ? 1'b0 : r_e_level);
      r_timeout <= w_timeout;
    end
  end

  assign en_tap          = r_tap;
  assign en_q            = r_en_q;
  assign en_e            = r_en_e;
  assign en_q_n          = r_en_q_n;
  assign en_e_n          = r_en_e_n;
  assign q_level         = r_q_level;
  assign e_level         = r_e_level;
  assign stretched       = (r_state == c_ST_HELD);
  assign stretch_timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_clock_sequencer.sv
// tb_clock_sequencer: checks a default instance and a 16-phase instance against
// a cycle-level behavioural model, plus hand-computed timing landmarks.
`default_nettype none

module tb_clock_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0;
  logic req_b = 1'b0;

  always #5 clk = ~clk;

  logic [1:0] tap_a, tap_b;
  logic eq_a, ee_a, eqn_a, een_a, ql_a, el_a, st_a, to_a;
  logic eq_b, ee_b, eqn_b, een_b, ql_b, el_b, st_b, to_b;
  logic [3:0] fp_a, cp_a, fp_b, cp_b;

  clock_sequencer u_a (
    .clk(clk), .rst(rst), .stretch_req(req_a), .en_tap(tap_a),
    .en_q(eq_a), .en_e(ee_a), .en_q_n(eqn_a), .en_e_n(een_a),
    .q_level(ql_a), .e_level(el_a), .stretched(st_a), .stretch_timeout(to_a),
    .free_phase(fp_a), .cpu_phase(cp_a)
  );

  clock_sequencer #(
    .PHASES(16), .N_TAP(2), .TAP_MASK(32'h0F00_8001),
    .Q_PHASE(0), .E_PHASE(4), .QN_PHASE(8), .EN_PHASE(12),
    .HOLD_PHASE(11), .RESET_PHASE(3), .MAX_STRETCH(2)
  ) u_b (
    .clk(clk), .rst(rst), .stretch_req(req_b), .en_tap(tap_b),
    .en_q(eq_b), .en_e(ee_b), .en_q_n(eqn_b), .en_e_n(een_b),
    .q_level(ql_b), .e_level(el_b), .stretched(st_b), .stretch_timeout(to_b),
    .free_phase(fp_b), .cpu_phase(cp_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference configuration of both instances.
  int         P  [2] = '{12, 16};
  int         QP [2] = '{0, 0};
  int         EP [2] = '{3, 4};
  int         QNP[2] = '{6, 8};
  int         ENP[2] = '{9, 12};
  int         HP [2] = '{8, 11};
  int         MX [2] = '{4, 2};
  logic [15:0] M0[2] = '{16'h0AAA, 16'h8001};
  logic [15:0] M1[2] = '{16'h0249, 16'h0F00};

  int   mf[2], mc[2], mlaps[2];
  bit   mheld[2];
  bit   [1:0] x_tap[2];
  bit   x_q[2], x_e[2], x_qn[2], x_en[2], x_ql[2], x_el[2], x_st[2], x_to[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mf[k] = 3; mc[k] = 3; mlaps[k] = 0; mheld[k] = 0;
        x_tap[k] = 0; x_q[k] = 0; x_e[k] = 0; x_qn[k] = 0; x_en[k] = 0;
        x_ql[k] = 0; x_el[k] = 0; x_st[k] = 0; x_to[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit r;
        bit adv;
        bit to;
        r = (k == 0) ? req_a : req_b;
        x_ql[k]  = x_q[k] ? 1'b1 : (x_qn[k] ? 1'b0 : x_ql[k]);
        x_el[k]  = x_e[k] ? 1'b1 : (x_en[k] ? 1'b0 : x_el[k]);
        x_tap[k] = {M1[k][mf[k]], M0[k][mf[k]]};
        x_q[k]   = (mc[k] == QP[k]);
        x_e[k]   = (mc[k] == EP[k]);
        x_qn[k]  = (mc[k] == QNP[k]);
        x_en[k]  = (mc[k] == ENP[k]);
        adv = 1; to = 0;
        if (!mheld[k]) begin
          if (mc[k] == HP[k] && r) begin
            adv = 0; mheld[k] = 1; mlaps[k] = 0;
          end
        end else if (mf[k] != HP[k]) begin
          adv = 0;
        end else if (!r) begin
          mheld[k] = 0;
        end else if (mlaps[k] == MX[k] - 1) begin
          mheld[k] = 0; to = 1;
        end else begin
          mlaps[k] = mlaps[k] + 1; adv = 0;
        end
        x_st[k] = mheld[k];
        x_to[k] = to;
        mf[k] = (mf[k] + 1) % P[k];
        if (adv) mc[k] = (mc[k] + 1) % P[k];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        logic [17:0] av;
        logic [17:0] ev;
        if (k == 0) av = {tap_a, eq_a, ee_a, eqn_a, een_a, ql_a, el_a, st_a, to_a, fp_a, cp_a};
        else        av = {tap_b, eq_b, ee_b, eqn_b, een_b, ql_b, el_b, st_b, to_b, fp_b, cp_b};
        ev = {x_tap[k], x_q[k], x_e[k], x_qn[k], x_en[k], x_ql[k], x_el[k],
              x_st[k], x_to[k], 4'(mf[k]), 4'(mc[k])};
        checks++;
        if (av !== ev) begin
          errors++;
          $display("FAIL model_cmp inst %0d cyc %0d actual %h expected %h", k, cyc, av, ev);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int sel(input int s);
    case (s)
      0: return int'(cp_a);
      1: return int'(cp_b);
      2: return int'(st_a);
      3: return int'(st_b);
      default: return 0;
    endcase
  endfunction

  task automatic wait_until(input string name, input int s, input int val, input int limit);
    int n;
    n = 0;
    while (sel(s) != val && n < limit) begin
      tick();
      n++;
    end
    if (sel(s) != val) chk(name, sel(s), val);
  endtask

  initial begin
    int fe_a, se_a, fqn_a, fen_a, fq_a, fe_b, se_b, elc;
    int t0, t1, u0, u1, fe, fen, stc, toc, fall, rise2;
    bit started;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_free", int'(fp_a), 3);
    chk("reset_cpu", int'(cp_a), 3);
    chk("reset_outs", int'({tap_a, eq_a, ee_a, eqn_a, een_a, ql_a, el_a, st_a, to_a}), 0);
    rst = 1'b0;

    fe_a = -1; se_a = -1; fqn_a = -1; fen_a = -1; fq_a = -1; fe_b = -1; se_b = -1; elc = 0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (ee_a) begin if (fe_a < 0) fe_a = n; else if (se_a < 0) se_a = n; end
      if (eqn_a && fqn_a < 0) fqn_a = n;
      if (een_a && fen_a < 0) fen_a = n;
      if (eq_a && fq_a < 0) fq_a = n;
      if (ee_b) begin if (fe_b < 0) fe_b = n; else if (se_b < 0) se_b = n; end
      if (n <= 12 && el_a) elc++;
      if (n == 2) chk("e_level_c2", int'(el_a), 1);
      if (n == 8) chk("e_level_c8", int'(el_a), 0);
    end
    chk("first_en_e", fe_a, 1);
    chk("first_en_q_n", fqn_a, 4);
    chk("first_en_e_n", fen_a, 7);
    chk("first_en_q", fq_a, 10);
    chk("period_a", se_a - fe_a, 12);
    chk("e_level_hi_cycles", elc, 6);
    chk("first_en_e_b", fe_b, 2);
    chk("period_b", se_b - fe_b, 16);

    t0 = 0; t1 = 0; u0 = 0; u1 = 0;
    for (int n = 0; n < 160; n++) begin
      tick();
      if (n < 120) begin t0 += int'(tap_a[0]); t1 += int'(tap_a[1]); end
      u0 += int'(tap_b[0]); u1 += int'(tap_b[1]);
    end
    chk("tap6m_count", t0, 60);
    chk("tap4m_count", t1, 40);
    chk("tapb0_count", u0, 20);
    chk("tapb1_count", u1, 40);

    // One-lap stretch on the default instance.
    wait_until("wait_cpu_a1", 0, 1, 30);
    fe = -1; fen = -1; stc = 0; t0 = 0; t1 = 0; started = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (cp_a == 4'd5 && !started) begin req_a = 1'b1; started = 1; end
      if (ee_a && fe < 0) fe = n;
      if (een_a && fe >= 0 && fen < 0) fen = n;
      if (st_a) begin stc++; if (stc == 4) req_a = 1'b0; end
      t0 += int'(tap_a[0]); t1 += int'(tap_a[1]);
    end
    chk("stretch_e_to_en_gap", fen - fe, 18);
    chk("stretch_len", stc, 12);
    chk("stretch_tap6m", t0, 30);
    chk("stretch_tap4m", t1, 20);
    chk("realigned", int'(fp_a), int'(cp_a));

    // Held request: forced release after MAX_STRETCH laps, then re-entry.
    wait_until("wait_cpu_a5", 0, 5, 30);
    req_a = 1'b1;
    stc = 0; toc = 0; fall = -1; rise2 = -1;
    for (int n = 0; n < 120; n++) begin
      tick();
      if (st_a && fall < 0) stc++;
      if (!st_a && stc > 0 && fall < 0) fall = n;
      if (st_a && fall >= 0 && rise2 < 0) begin rise2 = n; req_a = 1'b0; end
      toc += int'(to_a);
    end
    chk("timeout_len", stc, 48);
    chk("timeout_pulses", toc, 1);
    chk("restretch_gap", rise2 - fall, 12);

    // Asynchronous reset in the middle of a stretch.
    wait_until("wait_cpu_a5b", 0, 5, 30);
    req_a = 1'b1;
    wait_until("wait_st_a", 2, 1, 30);
    tick(); tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_free", int'(fp_a), 3);
    chk("arst_cpu", int'(cp_a), 3);
    chk("arst_outs", int'({tap_a, eq_a, ee_a, eqn_a, een_a, ql_a, el_a, st_a, to_a}), 0);
    chk("arst_outs_b", int'({tap_b, eq_b, ee_b, eqn_b, een_b, ql_b, el_b, st_b, to_b}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_a = 1'b0;

    // One-lap stretch on the 16-phase instance.
    wait_until("wait_cpu_b1", 1, 1, 40);
    fe = -1; fen = -1; stc = 0; u0 = 0; u1 = 0; started = 0;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (cp_b == 4'd5 && !started) begin req_b = 1'b1; started = 1; end
      if (ee_b && fe < 0) fe = n;
      if (een_b && fe >= 0 && fen < 0) fen = n;
      if (st_b) begin stc++; if (stc == 4) req_b = 1'b0; end
      u0 += int'(tap_b[0]); u1 += int'(tap_b[1]);
    end
    chk("b_stretch_gap", fen - fe, 24);
    chk("b_stretch_len", stc, 16);
    chk("b_stretch_tap0", u0, 8);
    chk("b_stretch_tap1", u1, 16);

    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 5) == 0) req_a = ~req_a;
      if ($urandom_range(0, 5) == 0) req_b = ~req_b;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (80) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_sequencer.md
# clock_sequencer

Parametrised clock-enable sequencer for the single-clock core. A free-running phase counter drives N programmable enable taps (video/pixel strobes). A second, stallable CPU phase counter drives the 6809 Q/E quadrature enables and levels. The CPU counter supports whole-cycle stretch of the E-high interval for slow peripherals, so video timing is never disturbed.

## Interface
- PHASES, 12: master clocks per CPU cycle; must be ≥ 4.
- N_TAP, 2: number of free-running enable taps.
- TAP_MASK, 24'h249_AAA: tap i fires on phases set in bits [i*PHASES +: PHASES]. Default tap0 fires on odd phases (6M), tap1 on 0/3/6/9 (4M).
- Q_PHASE / E_PHASE / QN_PHASE / EN_PHASE, 0/3/6/9: CPU counter phases that decode en_q / en_e / en_q_n / en_e_n.
- HOLD_PHASE, 8: CPU phase at which a stretch holds; must differ from all four decode phases.
- RESET_PHASE, 3: value loaded into both counters by reset.
- MAX_STRETCH, 4: maximum stretch laps before forced release; must be ≥ 1.
- clk  in  1  master clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- stretch_req  in  1  request to extend the current CPU cycle.
- en_tap  out  N_TAP  one-cycle tap enables.
- en_q, en_e, en_q_n, en_e_n  out  1 each  one-cycle CPU edge enables.
- q_level, e_level  out  1 each  registered Q and E clock levels.
- stretched  out  1  CPU counter is held.
- stretch_timeout  out  1  one-cycle pulse on forced release.
- free_phase, cpu_phase  out  $clog2(PHASES) each  current counter values.

## Operation
- Both counters count 0..PHASES-1 and wrap PHASES-1 → 0. PW = $clog2(PHASES).
- The free counter advances every cycle. The CPU counter advances every cycle unless a hold applies. Outside a stretch, cpu_phase == free_phase.
- Hold entry: not stretched, cpu_phase == HOLD_PHASE and stretch_req = 1 → CPU counter does not advance; stretched ← 1; laps ← 0.
- While stretched, the CPU counter holds until a cycle with free_phase == HOLD_PHASE. On that cycle:
  - stretch_req = 0 → advance; stretched ← 0.
  - else laps == MAX_STRETCH-1 → advance; stretched ← 0; stretch_timeout ← 1 for one cycle.
  - else laps ← laps+1 and keep holding.
- stretch_req is sampled only at hold entry and at those lap points. A stretch therefore always adds k·PHASES cycles, with k in 1..MAX_STRETCH, and the counters realign on release.
- If stretch_req is still high after a timeout, the next arrival at HOLD_PHASE enters a new stretch.
- q_level is set by en_q and cleared by en_q_n. e_level is set by en_e and cleared by en_e_n.

## Timing
- All outputs are registered. A decode on counter value at cycle t appears at t+1. For example, en_e(t+1) = (cpu_phase(t) == E_PHASE) and en_tap[i](t+1) = TAP_MASK bit of free_phase(t).
- Because HOLD_PHASE is not a decode phase, held cycles produce no CPU enables. en_tap is unaffected by stretch.
- Levels change in the cycle after the corresponding enable.
- Reset, asynchronous: both counters ← RESET_PHASE; laps ← 0; every enable, level, stretched and stretch_timeout ← 0.
- Reset mid-stretch aborts the stretch with no timeout pulse.
- First clock after reset release: en_e = 1 (defaults).

## Structure
- clock_sequencer_pkg holds:
  - the PW width function;
  - the parameter-legality checks (PHASES ≥ 4, HOLD_PHASE distinct, all phases < PHASES, MAX_STRETCH ≥ 1), used by elaboration-time asserts;
  - default TAP_MASK constants: TAP_6M = 12'hAAA, TAP_4M = 12'h249.
- Sub-module phase_counter (PHASES, RESET_PHASE; inputs advance, clk, rst; output phase) is instantiated twice: free counter with advance tied 1, CPU counter driven by the stretch logic.

## Test plan
- Defaults, release reset: en_e at cycle 1, en_q_n at 4, en_e_n at 7, en_q at 10, period 12. e_level high for cycles 2–7. free_phase == cpu_phase throughout.
- Defaults, 120 cycles: en_tap[0] pulses 60 times, en_tap[1] 40 times. Pulses occur on the documented phases only.
- stretch_req high from cpu_phase 5, dropped 4 cycles after hold entry:
  - en_e → en_e_n spacing is 18 cycles;
  - stretched is high 12 cycles;
  - en_tap pattern is unchanged;
  - counters are equal after release.
- stretch_req held high, MAX_STRETCH = 4:
  - release after 48 held cycles;
  - stretch_timeout pulses once;
  - the next cycle's arrival at phase 8 stretches again.
- Assert rst asynchronously mid-stretch: all outputs 0 before the next clk edge; counters read 3; no timeout pulse.
- PHASES = 16, Q/E/QN/EN = 0/4/8/12, HOLD = 11: period 16; one-lap stretch adds 16 cycles; tap masks honour 16-bit fields.
